bcd_operand_editor: RTL and testbench

- Parametrised keypad-driven entry of NUM_OPS decimal operands of DIGITS_PER_OP BCD digits each, for the GCD demo and later multi-operand CPU programs.
- Provides cursor movement, wrap-around digit increment/decrement with hold-to-repeat, and clear.
- On start, performs a sequential BCD-to-binary conversion, then presents the binary operands to the CPU through a valid/ready handshake.
- Sits between the button debouncers and rv32i_cpu; digit and cursor outputs feed seg_display.

---
 rtl/bcd_operand_editor.sv | 185 ++++++++++++++++++
 tb/tb_bcd_operand_editor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_operand_editor.sv
// Keypad-driven editor for NUM_OPS decimal operands of DIGITS_PER_OP BCD
// digits each. Supports cursor movement, wrap-around digit increment and
// decrement with hold-to-repeat, and clear. On start, the digits are
// converted to binary one digit per cycle. The binary operands are then
// offered to the consumer through a valid/ready handshake.
module bcd_operand_editor #(
    parameter int NUM_OPS       = 2,
    parameter int DIGITS_PER_OP = 2,
    parameter int OUT_W         = 32,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int BLINK_HALF    = 25000000,
    localparam int N     = NUM_OPS * DIGITS_PER_OP,
    localparam int CUR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic                       btn_clear,
    input  logic                       start,
    input  logic                       op_ready,
    output logic [N*4-1:0]             digits,
    output logic [CUR_W-1:0]           cursor,
    output logic                       cursor_blink,
    output logic [NUM_OPS*OUT_W-1:0]   op_bin,
    output logic                       op_valid,
    output logic                       busy
);

    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
    localparam int BLK_W = $clog2(BLINK_HALF + 1);
    localparam int P_W   = (DIGITS_PER_OP > 1) ? $clog2(DIGITS_PER_OP) : 1;

    typedef enum logic [2:0] {
        BTN_NONE, BTN_CLEAR, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT
    } btn_t;

    typedef enum logic [1:0] {IDLE, CONV, VALID} state_t;

    btn_t                     active;
    btn_t                     prev_active;
    logic [CNT_W-1:0]         rpt_cnt;
    logic [CNT_W-1:0]         rpt_next;
    logic                     act_fire;
    logic [3:0]               cur_digit;
    logic [BLK_W-1:0]         blk_cnt;
    state_t                   state;
    logic [P_W-1:0]           p;
    logic [NUM_OPS*OUT_W-1:0] acc;
    logic [NUM_OPS*OUT_W-1:0] acc_next;

    // One Horner step of the decimal-to-binary conversion. The result is truncated to OUT_W.
    function automatic logic [OUT_W-1:0] mul10_add(input logic [OUT_W-1:0] a,
                                                   input logic [3:0]       d);
        return (a << 3) + (a << 1) + OUT_W'(d);
    endfunction

    // Fixed-priority button arbitration: clear > up > down > left > right
    always_comb begin
        active = BTN_NONE;
        if (btn_clear)      active = BTN_CLEAR;
        else if (btn_up)    active = BTN_UP;
        else if (btn_down)  active = BTN_DOWN;
        else if (btn_left)  active = BTN_LEFT;
        else if (btn_right) active = BTN_RIGHT;
    end

    // rpt_cnt holds the previous cycle's count, so this cycle's count is rpt_cnt+1;
    // fire on a new button or when the hold count reaches REPEAT_DELAY-1
    always_comb begin
        rpt_next = rpt_cnt + 1'b1;
        act_fire = 1'b0;
        if (active != BTN_NONE) begin
            if (active != prev_active)
                act_fire = 1'b1;
            else if (rpt_next == CNT_W'(REPEAT_DELAY - 1))
                act_fire = 1'b1;
        end
    end

    assign cur_digit = digits[{cursor, 2'b00} +: 4];

    // Hold-to-repeat counter; a repeat reloads so the next cycle's count is REPEAT_DELAY-REPEAT_PERIOD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt     <= '0;
            prev_active <= BTN_NONE;
        end else begin
            prev_active <= active;
            if (active == BTN_NONE || active != prev_active)
                rpt_cnt <= '0;
            else if (rpt_next == CNT_W'(REPEAT_DELAY - 1))
                rpt_cnt <= CNT_W'(REPEAT_DELAY - REPEAT_PERIOD - 1);
            else
                rpt_cnt <= rpt_next;
        end
    end

    // Apply edit actions; suppressed outside IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits <= '0;
            cursor <= '0;
        end else if (act_fire && state == IDLE) begin
            case (active)
                BTN_CLEAR: digits <= '0;
                BTN_UP:    digits[{cursor, 2'b00} +: 4] <=
                               (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
                BTN_DOWN:  digits[{cursor, 2'b00} +: 4] <=
                               (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
                BTN_LEFT:  cursor <= (cursor == CUR_W'(N - 1)) ? '0 : cursor + 1'b1;
                BTN_RIGHT: cursor <= (cursor == '0) ? CUR_W'(N - 1) : cursor - 1'b1;
                default:   ;
            endcase
        end
    end

    // Free-running cursor blink
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt      <= '0;
            cursor_blink <= 1'b0;
        end else if (blk_cnt == BLK_W'(BLINK_HALF - 1)) begin
            blk_cnt      <= '0;
            cursor_blink <= ~cursor_blink;
        end else begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end

    // Next accumulator values: all operands step in parallel on digit position p
    always_comb begin
        acc_next = '0;
        for (int j = 0; j < NUM_OPS; j++) begin
            acc_next[j*OUT_W +: OUT_W] =
                mul10_add(acc[j*OUT_W +: OUT_W],
                          digits[(j*DIGITS_PER_OP + int'(p))*4 +: 4]);
        end
    end

    // Conversion and handshake FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            p        <= '0;
            acc      <= '0;
            op_bin   <= '0;
            op_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CONV;
                        busy  <= 1'b1;
                        acc   <= '0;
                        p     <= P_W'(DIGITS_PER_OP - 1);
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    if (p == '0) begin
                        op_bin   <= acc_next;
                        op_valid <= 1'b1;
                        state    <= VALID;
                    end else begin
                        p <= p - 1'b1;
                    end
                end
                VALID: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_operand_editor.sv
// Directed bench for bcd_operand_editor with short repeat and blink timing.
module tb_bcd_operand_editor;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_up, btn_down, btn_left, btn_right, btn_clear;
    logic        start, op_ready;
    logic [15:0] digits;
    logic [1:0]  cursor;
    logic        cursor_blink;
    logic [63:0] op_bin;
    logic        op_valid, busy;

    int n_cmp = 0;
    int n_err = 0;

    bcd_operand_editor #(
        .NUM_OPS(2), .DIGITS_PER_OP(2), .OUT_W(32),
        .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .BLINK_HALF(5)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_clear(btn_clear),
        .start(start), .op_ready(op_ready),
        .digits(digits), .cursor(cursor), .cursor_blink(cursor_blink),
        .op_bin(op_bin), .op_valid(op_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mask = {clear, up, down, left, right}; hold one cycle, then release one cycle
    task automatic press(input logic [4:0] mask);
        {btn_clear, btn_up, btn_down, btn_left, btn_right} = mask;
        tick();
        {btn_clear, btn_up, btn_down, btn_left, btn_right} = 5'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        {btn_clear, btn_up, btn_down, btn_left, btn_right} = 5'b0;
        start = 1'b0;
        op_ready = 1'b0;
        tick();
        check("rst_digits", digits, 0);
        check("rst_cursor", cursor, 0);
        check("rst_blink", cursor_blink, 0);
        check("rst_op_bin", op_bin, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_busy", busy, 0);
        tick();
        rst = 1'b0;

        // Blink toggles after BLINK_HALF=5 edges
        repeat (4) tick();
        check("blink_before", cursor_blink, 0);
        tick();
        check("blink_toggle", cursor_blink, 1);

        // Single up press
        press(5'b01000);
        check("up_once", digits, 16'h0001);

        // Clear, then down wraps 0 -> 9
        press(5'b10000);
        check("clear", digits, 16'h0000);
        press(5'b00100);
        check("down_wrap", digits, 16'h0009);

        // Right wraps 0 -> 3, left wraps 3 -> 0
        press(5'b00001);
        check("right_wrap", cursor, 3);
        press(5'b00010);
        check("left_wrap", cursor, 0);

        // Hold up 16 cycles: actions at hold cycles 0, 7, 11, 15
        press(5'b10000);
        btn_up = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0)  check("hold_c0", digits, 16'h0001);
            if (i == 6)  check("hold_c6", digits, 16'h0001);
            if (i == 7)  check("hold_c7", digits, 16'h0002);
            if (i == 10) check("hold_c10", digits, 16'h0002);
            if (i == 11) check("hold_c11", digits, 16'h0003);
        end
        check("hold_c15", digits, 16'h0004);
        btn_up = 1'b0;
        tick();
        check("hold_release", digits, 16'h0004);

        // Enter 48 / 18
        press(5'b10000);
        press(5'b00100);
        press(5'b00100);
        press(5'b00010);
        press(5'b01000);
        press(5'b00010);
        press(5'b00100);
        press(5'b00100);
        press(5'b00010);
        repeat (4) press(5'b01000);
        check("entry_digits", digits, 16'h4818);
        check("entry_cursor", cursor, 3);

        // Conversion
        start = 1'b1;
        tick();
        start = 1'b0;
        check("conv_busy_t1", busy, 1);
        check("conv_valid_t1", op_valid, 0);
        tick();
        check("conv_valid_t2", op_valid, 0);
        tick();
        check("conv_valid_t3", op_valid, 1);
        check("conv_op0", op_bin[31:0], 18);
        check("conv_op1", op_bin[63:32], 48);

        // Edits and restart ignored while in VALID
        press(5'b01000);
        press(5'b10000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("valid_digits_kept", digits, 16'h4818);
        check("valid_still", op_valid, 1);
        check("valid_busy", busy, 1);
        check("valid_op_bin", op_bin, {32'd48, 32'd18});

        // Handshake
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check("hs_valid_low", op_valid, 0);
        check("hs_busy_low", busy, 0);
        check("hs_op_bin_kept", op_bin, {32'd48, 32'd18});

        // Asynchronous reset during CONV
        start = 1'b1;
        tick();
        start = 1'b0;
        check("conv2_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", op_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_digits", digits, 0);
        check("arst_op_bin", op_bin, 0);
        rst = 1'b0;
        tick();

        // Up and left together: only up acts
        press(5'b01010);
        check("prio_digits", digits, 16'h0001);
        check("prio_cursor", cursor, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
